// File: rtl/b32_shifter_seq.sv
// rtl/b32_shifter_seq.sv - bit-serial barrel shifter (SLL/SRL/SRA/ROR), one bit per clock
//
// Ports:
//   clk   - single clock, rising edge
//   rst   - synchronous active-high reset
//   start - begin an operation (accepted only while ready)
//   mode  - 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   X     - operand
//   S     - unsigned shift amount, 0..N-1
//   ready - idle, able to accept start
//   busy  - shifting in progress
//   done  - one-cycle result-valid pulse
//   Z     - registered result, held until the next completed operation
module b32_shifter_seq #(
  parameter  int N  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [N-1:0]  X,
  input  logic [SW-1:0] S,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  Z
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [1:0]    mreg_q, mreg_d;
  logic [N-1:0]  z_q, z_d;
  logic [N-1:0]  acc_step;

  // One-bit step of the accumulator for the captured mode.
  always_comb begin
    acc_step = acc_q;
    case (mreg_q)
      2'b00:   acc_step = {acc_q[N-2:0], 1'b0};
      2'b01:   acc_step = {1'b0, acc_q[N-1:1]};
      2'b10:   acc_step = {acc_q[N-1], acc_q[N-1:1]};
      default: acc_step = {acc_q[0], acc_q[N-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mreg_d  = mreg_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          acc_d   = X;
          cnt_d   = S;
          mreg_d  = mode;
        end
      end
      SHIFT: begin
        // The cnt==0 edge spends one extra cycle publishing acc, which
        // gives the fixed S+1 edges from accept to done.
        if (cnt_q != '0) begin
          acc_d = acc_step;
          cnt_d = cnt_q - SW'(1);
        end else begin
          z_d     = acc_q;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mreg_q  <= 2'b00;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mreg_q  <= mreg_d;
      z_q     <= z_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign Z     = z_q;

endmodule

// File: tb/tb_b32_shifter_seq.sv
// tb/tb_b32_shifter_seq.sv - self-checking bench for b32_shifter_seq
module tb_b32_shifter_seq;

  localparam int N = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] X;
  logic [4:0]  S;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] Z;

  int errors = 0;
  int checks = 0;

  b32_shifter_seq #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .X     (X),
    .S     (S),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .Z     (Z)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [1:0] m, input logic [31:0] x, input int s);
    logic [31:0] r;
    case (m)
      2'b00:   r = x << s;
      2'b01:   r = x >> s;
      2'b10:   r = $signed(x) >>> s;
      default: r = (s == 0) ? x : ((x >> s) | (x << (32 - s)));
    endcase
    return r;
  endfunction

  // Runs one operation from IDLE. lat = edges from accept to first done
  // (-1 on timeout). tail_ok = done dropped, ready back and Z held one edge later.
  task automatic run_op(input logic [1:0] m, input logic [31:0] x, input logic [4:0] s,
                        output int lat, output logic [31:0] z,
                        output logic tail_ok, output logic busy_ok);
    @(negedge clk);
    start = 1'b1; mode = m; X = x; S = s;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 2'($urandom); X = $urandom; S = 5'($urandom);
    lat = -1;
    busy_ok = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = e;
        break;
      end
      if (ready || !busy) busy_ok = 1'b0;
    end
    z = Z;
    @(posedge clk); #1;
    tail_ok = !done && ready && !busy && (Z === z);
  endtask

  task automatic check_op(input string name, input logic [1:0] m, input logic [31:0] x,
                          input logic [4:0] s, input logic [31:0] exp_z);
    int lat;
    logic [31:0] z;
    logic tail_ok, busy_ok;
    run_op(m, x, s, lat, z, tail_ok, busy_ok);
    checks++;
    if (z !== exp_z) begin
      errors++;
      $display("FAIL %s z m=%0d x=%h s=%0d got=%h exp=%h", name, m, x, s, z, exp_z);
    end
    checks++;
    if (lat !== int'(s) + 1) begin
      errors++;
      $display("FAIL %s latency m=%0d s=%0d got=%0d exp=%0d", name, m, s, lat, int'(s) + 1);
    end
    checks++;
    if (!(tail_ok && busy_ok)) begin
      errors++;
      $display("FAIL %s handshake tail_ok=%0b busy_ok=%0b exp=1/1", name, tail_ok, busy_ok);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; mode = 2'b11; X = 32'hFFFF_FFFF; S = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100 || Z !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got rbd=%b Z=%h exp rbd=100 Z=0", {ready, busy, done}, Z);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_spec_vectors();
    check_op("srl_vec", 2'b01, 32'hFFFF_FFF6, 5'd3, 32'h1FFF_FFFE);
    check_op("sra_vec", 2'b10, 32'hFFFF_FFF6, 5'd3, 32'hFFFF_FFFE);
    check_op("ror_vec", 2'b11, 32'h1, 5'd1, 32'h8000_0000);
    check_op("sll_max", 2'b00, 32'h8, 5'd31, 32'h0);
    for (int m = 0; m < 4; m++) check_op("s_zero", 2'(m), 32'h7, 5'd0, 32'h7);
    check_op("sll_edge", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
    check_op("srl_edge", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
    check_op("sra_edge", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    check_op("ror_edge", 2'b11, 32'h8000_0001, 5'd31, 32'h0000_0003);
  endtask

  task automatic test_sweep();
    int svals[8] = '{0, 1, 2, 3, 7, 15, 23, 31};
    int xvals[8] = '{8, 12, 14, 7, -15, -3, -1, -10};
    for (int m = 0; m < 4; m++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++)
          check_op("sweep", 2'(m), 32'(xvals[j]), 5'(svals[i]),
                   ref_model(2'(m), 32'(xvals[j]), svals[i]));
  endtask

  task automatic test_random();
    logic [1:0]  m;
    logic [31:0] x;
    logic [4:0]  s;
    for (int i = 0; i < 30; i++) begin
      m = 2'($urandom); x = $urandom; s = 5'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      check_op("random", m, x, s, ref_model(m, x, int'(s)));
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    int done_edge = -1;
    logic ready_seen = 1'b0;
    logic [31:0] zd = 32'h0;
    logic [31:0] exp_z;
    exp_z = ref_model(2'b11, 32'hA5A5_0F0F, 10);
    @(negedge clk);
    start = 1'b1; mode = 2'b11; X = 32'hA5A5_0F0F; S = 5'd10;
    @(posedge clk); #1;
    for (int e = 1; e <= 11; e++) begin
      @(negedge clk);
      start = 1'b1; mode = 2'($urandom); X = $urandom; S = 5'($urandom);
      @(posedge clk); #1;
      if (ready) ready_seen = 1'b1;
      if (done) begin pulses++; done_edge = e; zd = Z; end
    end
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 1 || done_edge !== 11) begin
      errors++;
      $display("FAIL ignore_start pulses got=%0d@%0d exp=1@11", pulses, done_edge);
    end
    checks++;
    if (zd !== exp_z) begin
      errors++;
      $display("FAIL ignore_start z got=%h exp=%h", zd, exp_z);
    end
    checks++;
    if (ready_seen !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start ready got=1 exp=0 during operation");
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    check_op("pre_abort", 2'b00, 32'h7, 5'd0, 32'h7);
    @(negedge clk);
    start = 1'b1; mode = 2'b00; X = 32'h1234_5678; S = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy, done} !== 3'b100 || Z !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort got rbd=%b Z=%h exp rbd=100 Z=0", {ready, busy, done}, Z);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 15; e++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || Z !== 32'h0) begin
      errors++;
      $display("FAIL reset_abort after got pulses=%0d Z=%h exp pulses=0 Z=0", pulses, Z);
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    logic [31:0] exp_z;
    exp_z = ref_model(2'b10, 32'h8000_0010, 2);
    @(negedge clk);
    start = 1'b1; mode = 2'b10; X = 32'h8000_0010; S = 5'd2;
    @(posedge clk); #1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        checks++;
        if ((e % 5) !== 3 || Z !== exp_z) begin
          errors++;
          $display("FAIL back_to_back pulse edge=%0d Z=%h exp edge%%5=3 Z=%h", e, Z, exp_z);
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (pulses !== 4) begin
      errors++;
      $display("FAIL back_to_back count got=%0d exp=4", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_sweep();
    test_random();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
